// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-bit FSM encodings,
// default parameter values and the counter-width helper.
`timescale 1ns/1ps
package sw_debounce_pkg;

  // Per-bit debounce FSM encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  // Default number of debounced switches.
  localparam int unsigned N_SW_DEFAULT = 4;

  // Default number of consecutive stable synchronized samples needed to
  // accept a change (about 10 ms at 100 MHz).
  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

  // The counter only has to reach DB_CYCLES-1, so clog2(DB_CYCLES) bits
  // are enough.  The floor of 1 keeps the vector legal for tiny values.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    if (cycles < 2) begin
      return 1;
    end
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One debounced switch: 2-flop synchronizer, IDLE/COUNT acceptance FSM
// with a stability counter, and registered rise/fall pulses.
//
// A change on the synchronized level is accepted on the DB_CYCLES-th
// consecutive edge at which it disagrees with the debounced level.  Any
// agreeing sample in between drops the FSM back to IDLE and restarts the
// count, so the counter never wraps.  o_change_d is the next-state value
// of (rise | fall) so the parent can register the combined valid pulse in
// the same cycle as the per-bit pulses.
`timescale 1ns/1ps
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_sw,
  output logic       o_sw,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_change_d,
  output logic [0:0] o_state
);

  localparam int unsigned CW = db_cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sw_q, sw_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          differ;

  // Synchronized level disagrees with the currently accepted level.
  assign differ = (sync2_q != sw_q);

  // Two-stage synchronizer; only the second stage is used downstream.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_sw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: count consecutive disagreeing samples, accept on the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (differ) begin
          // This edge is the first disagreeing sample.
          state_d = ST_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_COUNT: begin
        if (!differ) begin
          // Bounced back to the accepted level: abandon the count.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // DB_CYCLES-th consecutive disagreement: accept the new level.
          state_d = ST_IDLE;
          cnt_d   = '0;
          sw_d    = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM, counter, debounced level and edge pulses.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_sw       = sw_q;
  assign o_rise     = rise_q;
  assign o_fall     = fall_q;
  assign o_change_d = rise_d | fall_d;
  assign o_state    = state_q;

endmodule

// File: rtl/sw_debounce.sv
// Multi-switch debouncer: N_SW independent debounce channels plus a
// registered "anything changed" strobe.
//
// Output handshake: o_valid is a one-cycle strobe, high exactly in the
// cycles where at least one bit of o_rise/o_fall is high (and o_sw has
// just taken its new value).  There is no back-pressure; a consumer must
// sample on every cycle o_valid is high.
//
// o_dbg_state exposes each channel's FSM state (1 = counting) for
// observation; it has no functional role.
`timescale 1ns/1ps
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int unsigned N_SW      = N_SW_DEFAULT,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic            clock,
  input  logic            i_reset,
  input  logic [N_SW-1:0] i_sw,
  output logic [N_SW-1:0] o_sw,
  output logic [N_SW-1:0] o_rise,
  output logic [N_SW-1:0] o_fall,
  output logic            o_valid,
  output logic [N_SW-1:0] o_dbg_state
);

  logic [N_SW-1:0] change_d;
  logic            valid_q;

  // One independent debounce channel per switch.
  for (genvar g = 0; g < N_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .DB_CYCLES (DB_CYCLES)
    ) u_bit (
      .clock      (clock),
      .i_reset    (i_reset),
      .i_sw       (i_sw[g]),
      .o_sw       (o_sw[g]),
      .o_rise     (o_rise[g]),
      .o_fall     (o_fall[g]),
      .o_change_d (change_d[g]),
      .o_state    (o_dbg_state[g])
    );
  end

  // Registered OR of all channel pulses, aligned with o_rise/o_fall.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= |change_d;
    end
  end

  assign o_valid = valid_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce (N_SW=4, DB_CYCLES=4).  The driver applies one
// input vector per clock and pushes the expected outputs of that edge,
// computed by a window-based reference model, onto exp_q; a monitor pops
// and compares on every falling edge.  A few directed latency checks are
// made directly by the driver one time unit after the edge.
`timescale 1ns/1ps
module tb_sw_debounce;

  localparam int N_SW = 4;
  localparam int DB   = 4;
  localparam int W    = 4 * N_SW + 1;

  // ---------------- clock / reset ----------------
  logic            clock = 1'b0;
  logic            i_reset = 1'b1;
  logic [N_SW-1:0] i_sw = '0;
  logic [N_SW-1:0] o_sw, o_rise, o_fall, o_dbg_state;
  logic            o_valid;

  always #5 clock = ~clock;

  sw_debounce #(
    .N_SW      (N_SW),
    .DB_CYCLES (DB)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_sw        (i_sw),
    .o_sw        (o_sw),
    .o_rise      (o_rise),
    .o_fall      (o_fall),
    .o_valid     (o_valid),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int    tests = 0;
  int    fails = 0;
  string phase = "reset";
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Raw samples travel through a two-deep delay line (cleared by reset).
  // hist_q holds the synchronized samples seen at the last DB edges since
  // reset.  A bit changes when its last DB samples all disagree with the
  // accepted level; it is "counting" when its most recent sample(s)
  // disagree but fewer than DB of them do.
  logic [N_SW-1:0] m_s1 = '0;
  logic [N_SW-1:0] m_s2 = '0;
  logic [N_SW-1:0] m_osw = '0;
  logic [N_SW-1:0] hist_q[$];

  task automatic model_edge(input logic [N_SW-1:0] sw, input logic rst);
    logic [N_SW-1:0] sync, rise, fall, st, h;
    int run;
    rise = '0;
    fall = '0;
    st   = '0;
    if (rst) begin
      m_s1  = '0;
      m_s2  = '0;
      m_osw = '0;
      hist_q.delete();
    end else begin
      sync = m_s2;
      hist_q.push_back(sync);
      if (hist_q.size() > DB) void'(hist_q.pop_front());
      for (int b = 0; b < N_SW; b++) begin
        run = 0;
        for (int i = hist_q.size() - 1; i >= 0; i--) begin
          h = hist_q[i];
          if (h[b] == m_osw[b]) break;
          run++;
        end
        if (run == DB) begin
          rise[b]  = sync[b];
          fall[b]  = ~sync[b];
          m_osw[b] = sync[b];
        end else begin
          st[b] = (run > 0);
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    exp_q.push_back({m_osw, rise, fall, |(rise | fall), st});
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [N_SW-1:0] sw, input logic rst);
    i_sw    = sw;
    i_reset = rst;
    model_edge(sw, rst);
    @(posedge clock);
    #1;
  endtask

  task automatic check_now(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_exp, mon_act;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {o_sw, o_rise, o_fall, o_valid, o_dbg_state};
      tests++;
      if (mon_act !== mon_exp) begin
        fails++;
        $display("FAIL %s outputs: got sw=%h rise=%h fall=%h valid=%b st=%h, expected sw=%h rise=%h fall=%h valid=%b st=%h (t=%0t)",
                 phase, mon_act[16:13], mon_act[12:9], mon_act[8:5], mon_act[4], mon_act[3:0],
                 mon_exp[16:13], mon_exp[12:9], mon_exp[8:5], mon_exp[4], mon_exp[3:0], $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N_SW-1:0] cur;
    logic            rst;

    // Reset held with all switches high, then release.
    phase = "reset_high";
    repeat (3) begin
      cycle(4'hF, 1'b1);
      check_now("reset_outputs", {19'd0, o_sw, o_rise, o_fall, o_valid}, 32'd0);
    end
    for (int k = 1; k <= 7; k++) begin
      cycle(4'hF, 1'b0);
      if (k == 5) check_now("release_e5_sw", o_sw, 32'h0);
      if (k == 6) begin
        check_now("release_e6_sw", o_sw, 32'hF);
        check_now("release_e6_rise", o_rise, 32'hF);
        check_now("release_e6_valid", o_valid, 32'h1);
      end
      if (k == 7) check_now("release_e7_pulse", {o_rise, o_valid}, 32'h0);
    end

    // Clean step on bit 0, up then down.
    phase = "step_bit0";
    cycle(4'h0, 1'b1);
    cycle(4'h0, 1'b1);
    repeat (8) cycle(4'h0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h1, 1'b0);
      if (k == 5) check_now("bit0_rise_e5", o_sw[0], 32'h0);
      if (k == 6) check_now("bit0_rise_e6", {o_sw[0], o_rise[0]}, 32'h3);
      if (k == 7) check_now("bit0_rise_e7", o_rise, 32'h0);
    end
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h0, 1'b0);
      if (k == 5) check_now("bit0_fall_e5", o_sw[0], 32'h1);
      if (k == 6) check_now("bit0_fall_e6", {o_sw[0], o_fall[0]}, 32'h1);
    end

    // Bit 1 bouncing every two cycles, then held high.
    phase = "bounce_bit1";
    for (int i = 0; i < 40; i++) cycle(((i / 2) % 2 == 0) ? 4'h2 : 4'h0, 1'b0);
    check_now("bounce_no_change", o_sw, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cycle(4'h2, 1'b0);
      if (k == 5) check_now("bit1_settle_e5", o_sw[1], 32'h0);
      if (k == 6) check_now("bit1_settle_e6", {o_sw[1], o_rise[1]}, 32'h3);
    end

    // Bit 2 glitch shorter than the debounce window.
    phase = "glitch_bit2";
    repeat (3) cycle(4'h6, 1'b0);
    repeat (10) cycle(4'h2, 1'b0);
    check_now("bit2_idle", {o_sw[2], o_dbg_state[2]}, 32'h0);

    // Reset pulse while bit 3 is counting.
    phase = "reset_mid_count";
    repeat (4) cycle(4'hA, 1'b0);
    check_now("bit3_counting", o_dbg_state[3], 32'h1);
    cycle(4'hA, 1'b1);
    check_now("bit3_reset_abort", {o_sw, o_rise, o_dbg_state}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'hA, 1'b0);
      if (k == 5) check_now("bit3_restart_e5", o_sw, 32'h0);
      if (k == 6) check_now("bit3_restart_e6", {o_sw, o_rise}, 32'hAA);
    end

    // Bits 0 and 3 stepped together.
    phase = "simultaneous";
    repeat (10) cycle(4'h0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle(4'h9, 1'b0);
      if (k == 6) check_now("simul_e6", {o_rise, o_valid}, 32'h13);
      if (k == 7) check_now("simul_e7", o_valid, 32'h0);
    end

    // Randomized bouncing with occasional resets and quiet stretches.
    phase = "random";
    cur = 4'h9;
    for (int n = 0; n < 600; n++) begin
      if ((n % 100) < 90) begin
        for (int b = 0; b < N_SW; b++)
          if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      end
      rst = ($urandom_range(0, 149) == 0);
      cycle(cur, rst);
    end

    // Drain the scoreboard, bounded.
    phase = "drain";
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) begin
      @(negedge clock);
      #1;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: time %0t reached, expected stimulus to finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter N_SW, default 4: number of switch inputs debounced.
REQ-002 Parameter DB_CYCLES, default 1000000: consecutive stable synchronized samples required to accept a change; legal range 2..2^24.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 i_reset  input  1  synchronous reset, active-high.
REQ-005 i_sw  input  N_SW  raw, asynchronous, bouncing switch levels.
REQ-006 o_sw  output  N_SW  debounced switch levels; feeds the counter stage's i_sw.
REQ-007 o_rise  output  N_SW  one-cycle pulse per bit on an accepted 0->1 change.
REQ-008 o_fall  output  N_SW  one-cycle pulse per bit on an accepted 1->0 change.
REQ-009 o_valid  output  1  one-cycle pulse when any bit of o_sw changed on this edge.

Function
REQ-010 Each i_sw bit SHALL pass through a 2-flop synchronizer; only the second-flop value (sync) SHALL be used downstream.
REQ-011 Each bit SHALL run an independent FSM with states IDLE and COUNT, plus a counter of width clog2(DB_CYCLES).
REQ-012 IDLE: counter held at 0; when sync != o_sw, next state COUNT and counter becomes 1.
REQ-013 COUNT, sync == o_sw (bounce back): next state IDLE, counter cleared, o_sw unchanged, no pulse.
REQ-014 COUNT, sync != o_sw, counter < DB_CYCLES-1: counter increments, stays COUNT.
REQ-015 COUNT, sync != o_sw, counter == DB_CYCLES-1: o_sw bit takes sync, counter cleared, next state IDLE, matching o_rise/o_fall bit pulses high for exactly that one cycle.
REQ-016 Therefore o_sw SHALL change on the DB_CYCLES-th consecutive edge at which sync differs from o_sw; total latency from a clean i_sw step to o_sw is DB_CYCLES+2 clock edges.
REQ-017 Any single-sample disagreement SHALL restart the count from zero; counter SHALL never wrap.
REQ-018 o_rise, o_fall and o_valid SHALL be registered outputs; o_valid = OR of (o_rise | o_fall) for the same cycle.
REQ-019 Bits SHALL be fully independent; simultaneous accepted changes on several bits produce simultaneous pulses and one o_valid pulse.
REQ-020 o_rise and o_fall for a given bit SHALL never be high in the same cycle, and SHALL never pulse on consecutive cycles.

Reset
REQ-021 While i_reset is high at a clock edge: synchronizer flops, o_sw, o_rise, o_fall, o_valid and all counters SHALL be 0; all FSMs SHALL be IDLE.
REQ-022 Reset asserted mid-COUNT SHALL abort the count with no pulse emitted.
REQ-023 After reset release with i_sw high, o_sw SHALL rise only after the full DB_CYCLES+2 latency, with an o_rise pulse.

Structure
REQ-024 FSM state encodings (IDLE=0, COUNT=1) and the default DB_CYCLES SHALL live in the shared project package/include, not in this module.
REQ-025 One sub-module sw_debounce_bit (synchronizer + FSM + counter + edge pulses for one bit) SHALL be instantiated N_SW times via generate; sw_debounce adds only the o_valid OR.

Verification (DB_CYCLES=4, N_SW=4)
REQ-026 Reset with i_sw=4'b1111 held -> all outputs 0 during reset; after release o_sw=4'b1111 on edge 6, o_rise=4'b1111 and o_valid=1 for that one cycle only.
REQ-027 Clean step i_sw[0] 0->1 -> o_sw[0]=1 exactly 6 edges later, single o_rise[0] pulse; later 1->0 -> single o_fall[0] pulse after 6 edges.
REQ-028 i_sw[1] toggled every 2 cycles for 40 cycles then held 1 -> no change/pulse during bounce; o_sw[1]=1 at 6 edges after final step.
REQ-029 i_sw[2] high for 3 synchronized cycles then low -> o_sw[2] stays 0, no pulses, FSM back to IDLE.
REQ-030 i_reset pulsed 1 cycle during COUNT on bit 3 -> no pulse, o_sw[3]=0, count restarts; i_sw[0] and i_sw[3] stepped same cycle -> both o_rise bits and one o_valid pulse on the same edge.
